// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between a master and the SRAM-backed responder.
// Clock and reset travel as separate scalar ports.
interface axi_sram_slave_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 responder over a word-addressed RAM: independent read and write FSMs,
// one outstanding transaction each, FIXED/INCR/WRAP bursts with byte strobes.
module axi_sram_slave #(
   parameter int          ADDR_BITS = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          READ_LAT  = 1
) (
   input  logic            aclk,
   input  logic            aresetn,
   axi_sram_slave_if.slave bus
);
   localparam int IDX_BITS = ADDR_BITS - 2;
   localparam int WORDS    = 2 ** IDX_BITS;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [31:0] mem [0:WORDS-1];

   function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
      logic [2:0]  sz;
      logic [31:0] step;
      logic [31:0] mask;
      sz   = (size > 3'd2) ? 3'd2 : size;
      step = 32'd1 << sz;
      mask = (({24'd0, len} + 32'd1) << sz) - 32'd1;
      if (burst == 2'b00)
         next_addr = addr;
      else if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
         next_addr = (addr & ~mask) | ((addr + step) & mask);
      else
         next_addr = addr + step;
   endfunction

   function automatic logic in_range(input logic [31:0] addr);
      logic [31:0] off;
      off      = addr - BASE_ADDR;
      in_range = (off >> ADDR_BITS) == 32'd0;
   endfunction

   function automatic logic [IDX_BITS-1:0] word_idx(input logic [31:0] addr);
      logic [31:0] off;
      off      = addr - BASE_ADDR;
      word_idx = IDX_BITS'(off >> 2);
   endfunction

   // ---------------- read channel ----------------
   r_state_t    r_state_reg;
   logic [3:0]  r_id_reg;
   logic [31:0] r_addr_reg;
   logic [7:0]  r_len_reg, r_beat_reg;
   logic [2:0]  r_size_reg, r_cnt_reg;
   logic [1:0]  r_burst_reg, rresp_reg;
   logic        arready_reg, rvalid_reg, rlast_reg;
   logic [31:0] rdata_reg;

   // A beat is "issued" on the edge that loads its payload into the R registers.
   logic        issue;
   logic [31:0] iss_addr;
   logic [7:0]  iss_beat, iss_len;
   logic [1:0]  iss_burst;

   always_comb begin
      issue     = 1'b0;
      iss_addr  = r_addr_reg;
      iss_beat  = 8'd0;
      iss_len   = r_len_reg;
      iss_burst = r_burst_reg;
      case (r_state_reg)
         R_IDLE: if (bus.arvalid && READ_LAT == 0) begin
            issue     = 1'b1;
            iss_addr  = bus.araddr;
            iss_len   = bus.arlen;
            iss_burst = bus.arburst;
         end
         R_WAIT: if (r_cnt_reg <= 3'd1) issue = 1'b1;
         R_DATA: if (bus.rready && !rlast_reg) begin
            issue    = 1'b1;
            iss_addr = next_addr(r_addr_reg, r_len_reg, r_size_reg, r_burst_reg);
            iss_beat = r_beat_reg + 8'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state_reg <= R_IDLE;
         r_id_reg    <= 4'd0;
         r_addr_reg  <= 32'd0;
         r_len_reg   <= 8'd0;
         r_beat_reg  <= 8'd0;
         r_size_reg  <= 3'd0;
         r_cnt_reg   <= 3'd0;
         r_burst_reg <= 2'd0;
         arready_reg <= 1'b1;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= 32'd0;
         rresp_reg   <= 2'd0;
         rlast_reg   <= 1'b0;
      end else begin
         case (r_state_reg)
            R_IDLE: if (bus.arvalid) begin
               r_id_reg    <= bus.arid;
               r_addr_reg  <= bus.araddr;
               r_len_reg   <= bus.arlen;
               r_size_reg  <= bus.arsize;
               r_burst_reg <= bus.arburst;
               r_cnt_reg   <= 3'(READ_LAT);
               arready_reg <= 1'b0;
               r_state_reg <= (READ_LAT == 0) ? R_DATA : R_WAIT;
            end
            R_WAIT: begin
               if (issue) r_state_reg <= R_DATA;
               else       r_cnt_reg   <= r_cnt_reg - 3'd1;
            end
            R_DATA: if (bus.rready && rlast_reg) begin
               rvalid_reg  <= 1'b0;
               rlast_reg   <= 1'b0;
               arready_reg <= 1'b1;
               r_state_reg <= R_IDLE;
            end
            default: r_state_reg <= R_IDLE;
         endcase
         if (issue) begin
            rvalid_reg <= 1'b1;
            r_addr_reg <= iss_addr;
            r_beat_reg <= iss_beat;
            rdata_reg  <= in_range(iss_addr) ? mem[word_idx(iss_addr)] : 32'd0;
            rresp_reg  <= !in_range(iss_addr) ? 2'b11 : (iss_burst == 2'b11) ? 2'b10 : 2'b00;
            rlast_reg  <= (iss_beat == iss_len);
         end
      end
   end

   assign bus.arready = arready_reg;
   assign bus.rvalid  = rvalid_reg;
   assign bus.rid     = r_id_reg;
   assign bus.rdata   = rdata_reg;
   assign bus.rresp   = rresp_reg;
   assign bus.rlast   = rlast_reg;

   // ---------------- write channel ----------------
   w_state_t    w_state_reg;
   logic [3:0]  w_id_reg, bid_reg;
   logic [31:0] w_addr_reg;
   logic [7:0]  w_len_reg, w_beat_reg;
   logic [2:0]  w_size_reg;
   logic [1:0]  w_burst_reg, bresp_reg;
   logic        w_dec_reg, w_slv_reg;
   logic        awready_reg, wready_reg, bvalid_reg;

   logic w_hs, w_oor, w_last, w_mis;
   assign w_hs   = (w_state_reg == W_DATA) && bus.wvalid;
   assign w_oor  = !in_range(w_addr_reg);
   assign w_last = (w_beat_reg == w_len_reg);
   assign w_mis  = (bus.wlast != w_last);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_reg <= W_IDLE;
         w_id_reg    <= 4'd0;
         w_addr_reg  <= 32'd0;
         w_len_reg   <= 8'd0;
         w_beat_reg  <= 8'd0;
         w_size_reg  <= 3'd0;
         w_burst_reg <= 2'd0;
         w_dec_reg   <= 1'b0;
         w_slv_reg   <= 1'b0;
         awready_reg <= 1'b1;
         wready_reg  <= 1'b0;
         bvalid_reg  <= 1'b0;
         bid_reg     <= 4'd0;
         bresp_reg   <= 2'd0;
      end else begin
         case (w_state_reg)
            W_IDLE: if (bus.awvalid) begin
               w_id_reg    <= bus.awid;
               w_addr_reg  <= bus.awaddr;
               w_len_reg   <= bus.awlen;
               w_size_reg  <= bus.awsize;
               w_burst_reg <= bus.awburst;
               w_beat_reg  <= 8'd0;
               w_dec_reg   <= 1'b0;
               w_slv_reg   <= (bus.awburst == 2'b11);
               awready_reg <= 1'b0;
               wready_reg  <= 1'b1;
               w_state_reg <= W_DATA;
            end
            W_DATA: if (w_hs) begin
               if (w_last) begin
                  wready_reg  <= 1'b0;
                  bvalid_reg  <= 1'b1;
                  bid_reg     <= w_id_reg;
                  bresp_reg   <= (w_dec_reg || w_oor) ? 2'b11 : (w_slv_reg || w_mis) ? 2'b10 : 2'b00;
                  w_state_reg <= W_RESP;
               end else begin
                  w_addr_reg <= next_addr(w_addr_reg, w_len_reg, w_size_reg, w_burst_reg);
                  w_beat_reg <= w_beat_reg + 8'd1;
                  w_dec_reg  <= w_dec_reg | w_oor;
                  w_slv_reg  <= w_slv_reg | w_mis;
               end
            end
            W_RESP: if (bus.bready) begin
               bvalid_reg  <= 1'b0;
               awready_reg <= 1'b1;
               w_state_reg <= W_IDLE;
            end
            default: w_state_reg <= W_IDLE;
         endcase
      end
   end

   // RAM write port; kept free of reset so it maps onto block RAM.
   always_ff @(posedge aclk) begin
      if (w_hs && !w_oor) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.wstrb[i]) mem[word_idx(w_addr_reg)][i*8 +: 8] <= bus.wdata[i*8 +: 8];
         end
      end
   end

   assign bus.awready = awready_reg;
   assign bus.wready  = wready_reg;
   assign bus.bvalid  = bvalid_reg;
   assign bus.bid     = bid_reg;
   assign bus.bresp   = bresp_reg;

   logic unused_inputs;
   assign unused_inputs = ^{bus.arlock, bus.arcache, bus.arprot,
                            bus.awlock, bus.awcache, bus.awprot, bus.wid};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave against a burst-level memory model.
`timescale 1ns/1ps
module tb_axi_sram_slave;
   localparam int          ADDR_BITS = 16;
   localparam logic [31:0] BASE      = 32'h8000_0000;
   localparam int          READ_LAT  = 1;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   axi_sram_slave_if bus();
   axi_sram_slave #(.ADDR_BITS(ADDR_BITS), .BASE_ADDR(BASE), .READ_LAT(READ_LAT))
      dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

   int errors = 0;
   int checks = 0;
   logic [31:0] model [int];
   logic [31:0] rd_log [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                             input int size, input int burst, input int i);
      logic [31:0] step, wb, lower;
      step = 32'd1 << ((size > 2) ? 2 : size);
      if (burst == 0) return start;
      if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
         wb    = 32'(len + 1) * step;
         lower = start - (start % wb);
         return lower + (((start - lower) + 32'(i) * step) % wb);
      end
      return start + 32'(i) * step;
   endfunction

   function automatic bit in_rng(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off < (32'd1 << ADDR_BITS);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] w;
      w = model.exists(widx(a)) ? model[widx(a)] : 32'hxxxx_xxxx;
      for (int j = 0; j < 4; j++) if (s[j]) w[j*8 +: 8] = d[j*8 +: 8];
      model[widx(a)] = w;
   endtask

   task automatic ar_send(input logic [31:0] addr, input int len, input int size,
                          input int burst, input logic [3:0] id);
      int t = 0;
      @(negedge aclk);
      bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = 3'(size);
      bus.arburst = 2'(burst); bus.arid = id; bus.arvalid = 1'b1;
      while (!bus.arready && t < 100) begin @(negedge aclk); t++; end
      @(posedge aclk); @(negedge aclk);
      bus.arvalid = 1'b0;
      if (t >= 100) check("ar_timeout", 32'(t), 32'd0);
   endtask

   task automatic aw_send(input logic [31:0] addr, input int len, input int size,
                          input int burst, input logic [3:0] id);
      int t = 0;
      @(negedge aclk);
      bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = 3'(size);
      bus.awburst = 2'(burst); bus.awid = id; bus.awvalid = 1'b1;
      while (!bus.awready && t < 100) begin @(negedge aclk); t++; end
      @(posedge aclk); @(negedge aclk);
      bus.awvalid = 1'b0;
      if (t >= 100) check("aw_timeout", 32'(t), 32'd0);
   endtask

   task automatic axi_read(input logic [31:0] addr, input int len, input int size,
                           input int burst, input logic [3:0] id, input bit stall);
      int lat, i, t, bad;
      logic [31:0] ea, ed, hold_d;
      logic hold_l;
      $display("RD addr=%h len=%0d size=%0d burst=%0d id=%0d", addr, len, size, burst, id);
      ar_send(addr, len, size, burst, id);
      lat = 1;
      while (!bus.rvalid && lat < 50) begin @(negedge aclk); lat++; end
      check("r_latency", 32'(lat), 32'(READ_LAT + 1));
      if (stall) begin
         bus.rready = 1'b0; bad = 0;
         hold_d = bus.rdata; hold_l = bus.rlast;
         repeat (5) begin
            @(negedge aclk);
            if (!bus.rvalid || bus.rdata !== hold_d || bus.rlast !== hold_l) bad++;
         end
         check("r_stall_stable", 32'(bad), 32'd0);
      end
      i = 0; t = 0;
      while (i <= len && t < 500) begin
         bus.rready = ($urandom_range(0, 3) != 0);
         if (bus.rvalid && bus.rready) begin
            ea = beat_addr(addr, len, size, burst, i);
            ed = in_rng(ea) ? model[widx(ea)] : 32'd0;
            check("r_data", bus.rdata, ed);
            check("r_resp", 32'(bus.rresp), !in_rng(ea) ? 32'd3 : (burst == 3) ? 32'd2 : 32'd0);
            check("r_last", 32'(bus.rlast), 32'(i == len));
            check("r_id", 32'(bus.rid), 32'(id));
            rd_log.push_back(bus.rdata);
            i++;
         end
         @(posedge aclk); @(negedge aclk);
         t++;
      end
      bus.rready = 1'b0;
      check("r_beats", 32'(i), 32'(len + 1));
      check("r_end_rvalid", 32'(bus.rvalid), 32'd0);
      check("r_end_arready", 32'(bus.arready), 32'd1);
   endtask

   task automatic axi_write(input logic [31:0] addr, input int len, input int size,
                            input int burst, input logic [3:0] id, input logic [31:0] d[$],
                            input logic [3:0] s[$], input int wlast_at);
      int i, t;
      bit dec, mis, done;
      logic [31:0] ea;
      $display("WR addr=%h len=%0d size=%0d burst=%0d id=%0d", addr, len, size, burst, id);
      aw_send(addr, len, size, burst, id);
      i = 0; t = 0; dec = 0; mis = 0;
      while (i <= len && t < 500) begin
         bus.wvalid = ($urandom_range(0, 3) != 0);
         bus.wdata  = d[i]; bus.wstrb = s[i]; bus.wlast = (i == wlast_at);
         bus.wid    = 4'($urandom);
         if (bus.wvalid && bus.wready) begin
            ea = beat_addr(addr, len, size, burst, i);
            if (in_rng(ea)) model_write(ea, d[i], s[i]);
            else dec = 1;
            if ((i == wlast_at) != (i == len)) mis = 1;
            i++;
         end
         @(posedge aclk); @(negedge aclk);
         t++;
      end
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      check("w_beats", 32'(i), 32'(len + 1));
      done = 0; t = 0;
      while (!done && t < 200) begin
         bus.bready = ($urandom_range(0, 2) != 0);
         if (bus.bvalid && bus.bready) begin
            check("b_id", 32'(bus.bid), 32'(id));
            check("b_resp", 32'(bus.bresp), dec ? 32'd3 : (mis || burst == 3) ? 32'd2 : 32'd0);
            done = 1;
         end
         @(posedge aclk); @(negedge aclk);
         t++;
      end
      bus.bready = 1'b0;
      check("b_seen", 32'(done), 32'd1);
      check("b_end_bvalid", 32'(bus.bvalid), 32'd0);
   endtask

   task automatic write_full(input logic [31:0] addr, input int len, input int burst,
                             input logic [31:0] first, input bit rnd);
      logic [31:0] d[$];
      logic [3:0]  s[$];
      for (int k = 0; k <= len; k++) begin
         d.push_back(rnd ? $urandom : first + 32'(k));
         s.push_back(4'hF);
      end
      axi_write(addr, len, 2, burst, 4'(len), d, s, len);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d[$];
      logic [3:0]  s[$];
      int t, bad, size, burst, len;
      logic [31:0] a;
      bus.arvalid = 0; bus.rready = 0; bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0;
      bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
      bus.arlock = 0; bus.arcache = 0; bus.arprot = 0;
      bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
      bus.awlock = 0; bus.awcache = 0; bus.awprot = 0;
      bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;

      #12;
      check("rst_arready", 32'(bus.arready), 32'd1);
      check("rst_awready", 32'(bus.awready), 32'd1);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_wready", 32'(bus.wready), 32'd0);
      check("rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("rst_rpayload", {bus.rid, bus.rresp, bus.rlast}, 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_bpayload", {bus.bid, bus.bresp}, 32'd0);
      @(negedge aclk); aresetn = 1'b1;

      for (int k = 0; k < 16; k++) write_full(BASE + 32'(k * 64), 15, 1, 0, 1);
      write_full(BASE, 0, 1, 32'hDEADBEEF, 0);

      rd_log.delete();
      axi_read(BASE, 0, 2, 1, 4'd3, 0);
      check("single_read", rd_log[0], 32'hDEADBEEF);

      write_full(BASE + 32'h100, 3, 1, 32'd1, 0);
      rd_log.delete();
      axi_read(BASE + 32'h100, 3, 2, 1, 4'd9, 0);
      for (int k = 0; k < 4; k++) check("incr_readback", rd_log[k], 32'(k + 1));

      rd_log.delete();
      axi_read(BASE + 32'h108, 3, 2, 2, 4'd4, 0);
      check("wrap_b0", rd_log[0], 32'd3);
      check("wrap_b1", rd_log[1], 32'd4);
      check("wrap_b2", rd_log[2], 32'd1);
      check("wrap_b3", rd_log[3], 32'd2);

      write_full(BASE + 32'h200, 0, 1, 32'd0, 0);
      d = '{32'hAABBCCDD}; s = '{4'b0101};
      axi_write(BASE + 32'h200, 0, 2, 1, 4'd6, d, s, 0);
      d = '{32'h11111111, 32'h22222222}; s = '{4'hF, 4'hF};
      axi_write(BASE + 32'h204, 1, 2, 0, 4'd7, d, s, 1);
      rd_log.delete();
      axi_read(BASE + 32'h200, 1, 2, 1, 4'd1, 0);
      check("strobe_word", rd_log[0], 32'h00BB00DD);
      check("fixed_word", rd_log[1], 32'h22222222);

      axi_read(BASE + 32'h40, 3, 2, 1, 4'd2, 1);
      rd_log.delete();
      axi_read(BASE + (32'd1 << ADDR_BITS), 0, 2, 1, 4'd5, 0);
      axi_read(BASE - 32'd4, 0, 2, 1, 4'd5, 0);
      check("decerr_rdata", rd_log[0], 32'd0);
      axi_read(BASE + 32'h80, 2, 2, 3, 4'd8, 0);

      d = '{1, 2, 3, 4}; s = '{4'hF, 4'hF, 4'hF, 4'hF};
      axi_write(BASE + 32'h300, 3, 2, 1, 4'd10, d, s, 1);
      axi_write(BASE + 32'hFFF8, 3, 2, 1, 4'd11, d, s, 3);
      axi_read(BASE + 32'hFFF8, 3, 2, 1, 4'd12, 0);

      @(negedge aclk); bus.wvalid = 1'b1; bad = 0;
      repeat (3) begin if (bus.wready) bad++; @(negedge aclk); end
      bus.wvalid = 1'b0;
      check("w_before_aw_stall", 32'(bad), 32'd0);

      for (int n = 0; n < 24; n++) begin
         size  = $urandom_range(0, 2);
         burst = $urandom_range(0, 2);
         case ($urandom_range(0, 3))
            0: len = 1; 1: len = 3; 2: len = 7; default: len = 15;
         endcase
         if (burst != 2) len = $urandom_range(0, 15);
         a = BASE + ($urandom_range(0, 32'h2C0) & ~((32'd1 << size) - 32'd1));
         if (n % 2 == 0) begin
            d.delete(); s.delete();
            for (int k = 0; k <= len; k++) begin d.push_back($urandom); s.push_back(4'($urandom)); end
            axi_write(a, len, size, burst, 4'($urandom), d, s, len);
         end else begin
            axi_read(a, len, size, burst, 4'($urandom), 0);
         end
      end

      $display("RST abort mid-burst");
      aw_send(BASE + 32'h380, 3, 2, 1, 4'd13);
      bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < 50) begin @(negedge aclk); t++; end
      @(posedge aclk); @(negedge aclk);
      bus.wvalid = 1'b0;
      model_write(BASE + 32'h380, 32'hCAFEF00D, 4'hF);
      ar_send(BASE, 3, 2, 1, 4'd7);
      t = 0;
      while (!bus.rvalid && t < 50) begin @(negedge aclk); t++; end
      bus.rready = 1'b1;
      @(posedge aclk); @(negedge aclk);
      bus.rready = 1'b0;
      check("abort_beat2_valid", 32'(bus.rvalid), 32'd1);
      #2 aresetn = 1'b0;
      #1;
      check("abort_rvalid", 32'(bus.rvalid), 32'd0);
      check("abort_arready", 32'(bus.arready), 32'd1);
      check("abort_wready", 32'(bus.wready), 32'd0);
      check("abort_bvalid", 32'(bus.bvalid), 32'd0);
      @(negedge aclk); aresetn = 1'b1;
      bus.rready = 1'b1; bus.bready = 1'b1; bad = 0;
      repeat (10) begin @(negedge aclk); if (bus.rvalid || bus.bvalid) bad++; end
      bus.rready = 1'b0; bus.bready = 1'b0;
      check("abort_no_stray", 32'(bad), 32'd0);
      check("abort_arready_after", 32'(bus.arready), 32'd1);
      axi_read(BASE + 32'h380, 0, 2, 1, 4'd2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder backed by an internal word-addressed RAM.
- Serves the CPU's AXI master (ar/r/aw/w/b) in simulation and FPGA bring-up builds, standing in for the memory controller.
- Read and write channels run as independent FSMs, one outstanding transaction each.
- Supports FIXED, INCR and WRAP bursts of up to 16 beats, narrow sizes and byte strobes.

Parameters:
- ADDR_BITS, 16, log2 of RAM size in bytes; RAM holds 2^(ADDR_BITS-2) 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.
- READ_LAT, 1, idle cycles between AR handshake and first R beat (0..7).

Ports:
- aclk in 1: clock, all logic on rising edge.
- aresetn in 1: asynchronous active-low reset.
- arid in 4, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arlock in 2, arcache in 4, arprot in 3: read address payload.
- arvalid in 1, arready out 1: read address handshake.
- rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1: read data channel.
- awid in 4, awaddr in 32, awlen in 8, awsize in 3, awburst in 2, awlock in 2, awcache in 4, awprot in 3: write address payload.
- awvalid in 1, awready out 1: write address handshake.
- wid in 4, wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1: write data channel.
- bid out 4, bresp out 2, bvalid out 1, bready in 1: write response channel.

Behaviour:
- Reset, asynchronous: read FSM to R_IDLE, write FSM to W_IDLE.
  - arready=1, awready=1; rvalid=0, wready=0, bvalid=0.
  - rid, rdata, rresp, rlast, bid, bresp all 0.
  - RAM contents are not reset.
- Reset asserted mid-burst aborts the burst immediately; no further beats or responses are issued.
- Handshake completes on the clock edge where valid & ready. Outputs are registered.
- A valid output is held, with its payload stable, until accepted.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch id/addr/len/size/burst and load delay counter with READ_LAT.
  - R_WAIT: decrement the counter; when it reaches 0, go to R_DATA. With READ_LAT=0, go straight to R_DATA, so first rvalid is the cycle after AR handshake.
  - R_DATA: rvalid=1; rlast=1 on beat arlen. On R handshake, advance address and beat count; after the last beat, return to R_IDLE with arready=1 the next cycle.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch payload and go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the lanes enabled by wstrb to the current word, then advances the address.
  - After beat awlen is accepted, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched awid. On B handshake, return to W_IDLE.
  - W beats presented before the AW handshake stall (wready=0). wid is ignored.
- Address sequencing, with step = 1<<size and size>2 treated as 2:
  - FIXED (00): address constant for the whole burst.
  - INCR (01): address += step each beat.
  - WRAP (10): wrap boundary = (len+1)*step, aligned down. The address increments and wraps to the boundary base on reaching the boundary end. len must be 1/3/7/15; any other len is treated as INCR.
  - Burst 11: treated as INCR, and every beat responds SLVERR (2'b10).
- Range check: an address outside [BASE_ADDR, BASE_ADDR+2^ADDR_BITS) gives DECERR (2'b11).
  - Reads: DECERR on that beat with rdata=0.
  - Writes: the beat is dropped, and bresp=DECERR if any beat of the burst was out of range.
- Read data is the whole 32-bit word at addr[ADDR_BITS-1:2] regardless of size; the master selects lanes.
- wlast mismatch (wlast=1 before beat awlen, or 0 on beat awlen): the beat count alone ends the burst, and bresp=SLVERR unless DECERR already applies.
- Simultaneous read and write to the same word in one cycle: the read beat returns the old data. A write is visible to any R beat issued on a later cycle.
- Lock, cache and prot inputs are ignored. Exclusive access is unsupported; responses are never EXOKAY.

Test Plan:
- Single read, READ_LAT=1: RAM[0]=32'hDEADBEEF; AR addr 0, len 0, size 2, INCR, id 3 at cycle T -> rvalid at T+2, rdata DEADBEEF, rid 3, rresp 0, rlast 1.
- INCR write then read, 4 beats: AW addr 0x100, len 3, data 1,2,3,4, strb F -> bresp 0, bid=awid; read back the same burst -> 1,2,3,4 with rlast only on beat 4.
- WRAP read: addr 0x108, len 3, size 2 -> beats read words 0x108, 0x10C, 0x100, 0x104.
- Strobes and FIXED: write 32'hAABBCCDD strb 4'b0101 to a word preset to 0 -> read gives 32'h00BB00DD. FIXED write of 2 beats -> only the second value remains.
- Backpressure and errors: hold rready=0 for 5 cycles -> rvalid, rdata, rlast stable. Read at BASE_ADDR+2^ADDR_BITS -> rresp 2'b11, rdata 0. Early wlast -> bresp 2'b10.
- Async reset mid-burst: drop aresetn during beat 2 of 4 -> rvalid=0 immediately, arready=1 after release, no stray B response.
